// File: rtl/ex_mem_stage_if.sv
// ----------------------------------------------------------------------------
// ex_mem_stage_if
// Data-memory bus between the EX/MEM stage (master) and the data memory or
// cache (slave). One request is outstanding at a time; the slave completes it
// by pulsing dhit, and on reads returns the word on dmemload in that cycle.
//
// Signals:
//   dmemREN   master->slave  read strobe
//   dmemWEN   master->slave  write strobe (never high together with dmemREN)
//   dmemaddr  master->slave  32-bit byte address
//   dmemstore master->slave  32-bit store data
//   dhit      slave->master  access complete
//   dmemload  slave->master  32-bit read data, valid with dhit on reads
// ----------------------------------------------------------------------------
interface ex_mem_stage_if;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        dhit;
  logic [31:0] dmemload;

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dmemload
  );

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dmemload
  );
endinterface

// File: rtl/ex_mem_stage.sv
// ----------------------------------------------------------------------------
// ex_mem_stage
// EX/MEM pipeline latch fused with the data-memory access controller. On each
// pipeline advance it captures the execute results (or a bubble on flush),
// issues a single dmem read or write for memory instructions and holds it,
// stalling upstream stages, until the memory answers with dhit. Latched
// control, ALU result, PC+4 and load data are presented to the MEM/WB latch.
//
// Optional build macro:
//   MEM_ACCESS_TIMEOUT_EN  when defined, an access that sees no dhit for
//                          TIMEOUT_CYCLES cycles is abandoned: load data is
//                          forced to 32'hDEADBEEF and mem_err latches high
//                          until reset. When undefined, accesses wait forever
//                          and mem_err is tied low.
//
// Parameters:
//   TIMEOUT_CYCLES  ACCESS cycles without dhit before timeout (1..255)
//
// Ports:
//   CLK, nRST                         clock, asynchronous active-low reset
//   iHit                              pipeline advance enable from fetch
//   flush                             capture a bubble instead of ex_* on advance
//   ex_dREN, ex_dWEN                  memory read / write request
//   ex_regWrite, ex_MemtoReg, ex_HALT control from execute
//   ex_wsel                           destination register
//   ex_aluOut                         ALU result / memory address
//   ex_storeData                      store data
//   ex_pcp4                           PC+4 for link writes
//   dmem                              data-memory bus (master side)
//   mem_regWrite, mem_MemtoReg,
//   mem_HALT, mem_wsel                latched control
//   mem_aluOut, mem_pcp4,
//   mem_loadData                      latched data to MEM/WB
//   mem_stall                         freeze upstream stages
//   mem_err                           sticky access timeout
// ----------------------------------------------------------------------------
module ex_mem_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 iHit,
  input  logic                 flush,
  input  logic                 ex_dREN,
  input  logic                 ex_dWEN,
  input  logic                 ex_regWrite,
  input  logic                 ex_MemtoReg,
  input  logic                 ex_HALT,
  input  logic [4:0]           ex_wsel,
  input  logic [31:0]          ex_aluOut,
  input  logic [31:0]          ex_storeData,
  input  logic [31:0]          ex_pcp4,
  ex_mem_stage_if.master       dmem,
  output logic                 mem_regWrite,
  output logic                 mem_MemtoReg,
  output logic                 mem_HALT,
  output logic [4:0]           mem_wsel,
  output logic [31:0]          mem_aluOut,
  output logic [31:0]          mem_pcp4,
  output logic [31:0]          mem_loadData,
  output logic                 mem_stall,
  output logic                 mem_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_rd;
  logic        r_wr;
  logic        r_regWrite;
  logic        r_MemtoReg;
  logic        r_HALT;
  logic [4:0]  r_wsel;
  logic [31:0] r_aluOut;
  logic [31:0] r_storeData;
  logic [31:0] r_pcp4;
  logic [31:0] r_loadData;

  logic        w_advance;
  logic        w_in_access;
  logic        w_cap_wr;
  logic        w_cap_rd;

  assign w_in_access = (r_state == ACCESS);
  assign w_advance   = iHit & ~w_in_access;

  // Write wins when execute raises both requests.
  assign w_cap_wr = ex_dWEN;
  assign w_cap_rd = ex_dREN & ~ex_dWEN;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] r_tocnt;
  logic       r_err;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_regWrite  <= 1'b0;
      r_MemtoReg  <= 1'b0;
      r_HALT      <= 1'b0;
      r_wsel      <= 5'd0;
      r_aluOut    <= 32'd0;
      r_storeData <= 32'd0;
      r_pcp4      <= 32'd0;
      r_loadData  <= 32'd0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      r_tocnt     <= 8'd0;
      r_err       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_advance) begin
            r_loadData <= 32'd0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            r_tocnt    <= 8'd0;
`endif
            if (flush) begin
              r_state     <= IDLE;
              r_rd        <= 1'b0;
              r_wr        <= 1'b0;
              r_regWrite  <= 1'b0;
              r_MemtoReg  <= 1'b0;
              r_HALT      <= 1'b0;
              r_wsel      <= 5'd0;
              r_aluOut    <= 32'd0;
              r_storeData <= 32'd0;
              r_pcp4      <= 32'd0;
            end else begin
              r_state     <= (w_cap_rd | w_cap_wr) ? ACCESS : IDLE;
              r_rd        <= w_cap_rd;
              r_wr        <= w_cap_wr;
              r_regWrite  <= ex_regWrite;
              r_MemtoReg  <= ex_MemtoReg;
              r_HALT      <= ex_HALT;
              r_wsel      <= ex_wsel;
              r_aluOut    <= ex_aluOut;
              r_storeData <= ex_storeData;
              r_pcp4      <= ex_pcp4;
            end
          end
        end
        ACCESS: begin
          // dhit beats a timeout landing in the same cycle.
          if (dmem.dhit) begin
            if (r_rd) begin
              r_loadData <= dmem.dmemload;
            end
            r_state <= DONE;
          end
`ifdef MEM_ACCESS_TIMEOUT_EN
          else if (r_tocnt == LP_TO_LAST) begin
            r_loadData <= 32'hDEADBEEF;
            r_err      <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_tocnt <= r_tocnt + 8'd1;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Strobes decode straight from the state register so an asynchronous
  // reset drops them without waiting for a clock edge.
  assign dmem.dmemREN   = w_in_access & r_rd;
  assign dmem.dmemWEN   = w_in_access & r_wr;
  assign dmem.dmemaddr  = r_aluOut;
  assign dmem.dmemstore = r_storeData;

  assign mem_stall    = w_in_access;
  assign mem_regWrite = r_regWrite;
  assign mem_MemtoReg = r_MemtoReg;
  assign mem_HALT     = r_HALT;
  assign mem_wsel     = r_wsel;
  assign mem_aluOut   = r_aluOut;
  assign mem_pcp4     = r_pcp4;
  assign mem_loadData = r_loadData;

`ifdef MEM_ACCESS_TIMEOUT_EN
  assign mem_err = r_err;
`else
  assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_mem_stage
// Directed bench for ex_mem_stage. A transaction-level model (latched
// instruction plus a "request pending" flag) predicts every output; a
// negedge compare process checks the DUT against it each cycle, and the
// directed sequence adds hand-computed literal checks.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ex_mem_stage;
  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iHit, flush;
  logic        ex_dREN, ex_dWEN, ex_regWrite, ex_MemtoReg, ex_HALT;
  logic [4:0]  ex_wsel;
  logic [31:0] ex_aluOut, ex_storeData, ex_pcp4;
  logic        mem_regWrite, mem_MemtoReg, mem_HALT;
  logic [4:0]  mem_wsel;
  logic [31:0] mem_aluOut, mem_pcp4, mem_loadData;
  logic        mem_stall, mem_err;

  ex_mem_stage_if dmem_if ();

  ex_mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .nRST(nRST), .iHit(iHit), .flush(flush),
    .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN), .ex_regWrite(ex_regWrite),
    .ex_MemtoReg(ex_MemtoReg), .ex_HALT(ex_HALT), .ex_wsel(ex_wsel),
    .ex_aluOut(ex_aluOut), .ex_storeData(ex_storeData), .ex_pcp4(ex_pcp4),
    .dmem(dmem_if.master),
    .mem_regWrite(mem_regWrite), .mem_MemtoReg(mem_MemtoReg),
    .mem_HALT(mem_HALT), .mem_wsel(mem_wsel), .mem_aluOut(mem_aluOut),
    .mem_pcp4(mem_pcp4), .mem_loadData(mem_loadData),
    .mem_stall(mem_stall), .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_rw, m_mr, m_halt;
  logic [4:0]  m_wsel;
  logic [31:0] m_alu, m_pc, m_st, m_ld;
  logic        m_isrd, m_iswr;   // kind of the latched instruction
  logic        m_pend;           // its memory request is still outstanding
  int          m_wait;           // cycles spent pending without dhit
  logic        m_err;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_rw <= 0; m_mr <= 0; m_halt <= 0; m_wsel <= 0;
      m_alu <= 0; m_pc <= 0; m_st <= 0; m_ld <= 0;
      m_isrd <= 0; m_iswr <= 0; m_pend <= 0; m_wait <= 0; m_err <= 0;
    end else if (iHit && !m_pend) begin
      m_ld   <= 0;
      m_wait <= 0;
      if (flush) begin
        m_rw <= 0; m_mr <= 0; m_halt <= 0; m_wsel <= 0;
        m_alu <= 0; m_pc <= 0; m_st <= 0;
        m_isrd <= 0; m_iswr <= 0; m_pend <= 0;
      end else begin
        m_rw <= ex_regWrite; m_mr <= ex_MemtoReg; m_halt <= ex_HALT;
        m_wsel <= ex_wsel; m_alu <= ex_aluOut; m_pc <= ex_pcp4;
        m_st <= ex_storeData;
        m_iswr <= ex_dWEN;
        m_isrd <= ex_dREN && !ex_dWEN;
        m_pend <= ex_dREN || ex_dWEN;
      end
    end else if (m_pend) begin
      if (dmem_if.dhit) begin
        m_pend <= 0;
        if (m_isrd) m_ld <= dmem_if.dmemload;
      end else begin
`ifdef MEM_ACCESS_TIMEOUT_EN
        if (m_wait + 1 == TO) begin
          m_pend <= 0;
          m_ld   <= 32'hDEADBEEF;
          m_err  <= 1;
        end else begin
          m_wait <= m_wait + 1;
        end
`else
        m_wait <= m_wait + 1;
`endif
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    chk("dmemREN",  {31'd0, dmem_if.dmemREN}, {31'd0, m_pend & m_isrd});
    chk("dmemWEN",  {31'd0, dmem_if.dmemWEN}, {31'd0, m_pend & m_iswr});
    chk("dmemaddr", dmem_if.dmemaddr, m_alu);
    chk("dmemstore", dmem_if.dmemstore, m_st);
    chk("regWrite", {31'd0, mem_regWrite}, {31'd0, m_rw});
    chk("MemtoReg", {31'd0, mem_MemtoReg}, {31'd0, m_mr});
    chk("HALT",     {31'd0, mem_HALT}, {31'd0, m_halt});
    chk("wsel",     {27'd0, mem_wsel}, {27'd0, m_wsel});
    chk("aluOut",   mem_aluOut, m_alu);
    chk("pcp4",     mem_pcp4, m_pc);
    chk("loadData", mem_loadData, m_ld);
    chk("stall",    {31'd0, mem_stall}, {31'd0, m_pend});
    chk("err",      {31'd0, mem_err}, {31'd0, m_err});
  end

  // ---------------- stimulus ----------------
  task automatic clear_ex();
    ex_dREN = 0; ex_dWEN = 0; ex_regWrite = 0; ex_MemtoReg = 0; ex_HALT = 0;
    ex_wsel = 0; ex_aluOut = 0; ex_storeData = 0; ex_pcp4 = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 0; iHit = 0; flush = 0; clear_ex();
    dmem_if.dhit = 0; dmem_if.dmemload = 0;
    repeat (2) @(negedge CLK);
    chk("lit_rst_stall", {31'd0, mem_stall}, 32'd0);
    chk("lit_rst_alu", mem_aluOut, 32'd0);
    nRST = 1;

    // Load, dhit on third ACCESS cycle
    ex_dREN = 1; ex_aluOut = 32'h100; ex_regWrite = 1; ex_MemtoReg = 1;
    ex_wsel = 5'd3; ex_pcp4 = 32'h44; iHit = 1; dmem_if.dmemload = 32'hCAFEF00D;
    @(negedge CLK); clear_ex();
    for (int k = 0; k < 3; k++) begin
      chk("lit_ld_ren", {31'd0, dmem_if.dmemREN}, 32'd1);
      chk("lit_ld_addr", dmem_if.dmemaddr, 32'h100);
      chk("lit_ld_stall", {31'd0, mem_stall}, 32'd1);
      dmem_if.dhit = (k == 2);
      @(negedge CLK);
    end
    dmem_if.dhit = 0; iHit = 0;
    chk("lit_ld_data", mem_loadData, 32'hCAFEF00D);
    chk("lit_ld_done_stall", {31'd0, mem_stall}, 32'd0);

    // Hold in DONE while iHit low
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("lit_hold_data", mem_loadData, 32'hCAFEF00D);
      chk("lit_hold_ren", {31'd0, dmem_if.dmemREN}, 32'd0);
      chk("lit_hold_wsel", {27'd0, mem_wsel}, 32'd3);
    end

    // Store with both requests high: write wins
    ex_dREN = 1; ex_dWEN = 1; ex_storeData = 32'h12345678; ex_aluOut = 32'h200;
    iHit = 1;
    @(negedge CLK); clear_ex();
    chk("lit_st_wen", {31'd0, dmem_if.dmemWEN}, 32'd1);
    chk("lit_st_ren", {31'd0, dmem_if.dmemREN}, 32'd0);
    chk("lit_st_data", dmem_if.dmemstore, 32'h12345678);
    chk("lit_st_ld_cleared", mem_loadData, 32'd0);
    dmem_if.dhit = 1;
    @(negedge CLK); dmem_if.dhit = 0;
    chk("lit_st_wen_drop", {31'd0, dmem_if.dmemWEN}, 32'd0);

    // ALU op then flush
    ex_regWrite = 1; ex_wsel = 5'd5; ex_aluOut = 32'd7;
    @(negedge CLK); clear_ex();
    chk("lit_alu_wsel", {27'd0, mem_wsel}, 32'd5);
    chk("lit_alu_out", mem_aluOut, 32'd7);
    flush = 1;
    @(negedge CLK); flush = 0;
    chk("lit_flush_wsel", {27'd0, mem_wsel}, 32'd0);
    chk("lit_flush_alu", mem_aluOut, 32'd0);

    // Flush during ACCESS is ignored
    ex_dREN = 1; ex_aluOut = 32'h300; dmem_if.dmemload = 32'h0BADF00D;
    @(negedge CLK); clear_ex();
    flush = 1; dmem_if.dhit = 1;
    @(negedge CLK); flush = 0; dmem_if.dhit = 0;
    chk("lit_flacc_data", mem_loadData, 32'h0BADF00D);
    chk("lit_flacc_addr", mem_aluOut, 32'h300);

    // Reset mid-ACCESS
    ex_dREN = 1; ex_aluOut = 32'h400; ex_wsel = 5'd7;
    @(negedge CLK); clear_ex();
    chk("lit_mid_ren", {31'd0, dmem_if.dmemREN}, 32'd1);
    #2 nRST = 0;
    #1;
    chk("lit_mid_ren_drop", {31'd0, dmem_if.dmemREN}, 32'd0);
    chk("lit_mid_alu", mem_aluOut, 32'd0);
    chk("lit_mid_wsel", {27'd0, mem_wsel}, 32'd0);
    chk("lit_mid_stall", {31'd0, mem_stall}, 32'd0);
    @(negedge CLK); nRST = 1;
    @(negedge CLK);
    chk("lit_post_rst_stall", {31'd0, mem_stall}, 32'd0);

`ifdef MEM_ACCESS_TIMEOUT_EN
    // dhit on the timeout cycle wins
    ex_dREN = 1; ex_aluOut = 32'h480; dmem_if.dmemload = 32'h55AA55AA;
    @(negedge CLK); clear_ex();
    for (int k = 0; k < TO; k++) begin
      dmem_if.dhit = (k == TO - 1);
      @(negedge CLK);
    end
    dmem_if.dhit = 0;
    chk("lit_to_hit_err", {31'd0, mem_err}, 32'd0);
    chk("lit_to_hit_data", mem_loadData, 32'h55AA55AA);

    // No dhit: timeout
    ex_dREN = 1; ex_aluOut = 32'h500;
    @(negedge CLK); clear_ex();
    for (int k = 0; k < TO; k++) begin
      chk("lit_to_stall", {31'd0, mem_stall}, 32'd1);
      @(negedge CLK);
    end
    chk("lit_to_err", {31'd0, mem_err}, 32'd1);
    chk("lit_to_data", mem_loadData, 32'hDEADBEEF);
    chk("lit_to_stall_drop", {31'd0, mem_stall}, 32'd0);
    ex_regWrite = 1; ex_wsel = 5'd9;
    @(negedge CLK); clear_ex();
    chk("lit_to_sticky", {31'd0, mem_err}, 32'd1);
    chk("lit_to_next_wsel", {27'd0, mem_wsel}, 32'd9);
`else
    // Long wait: no timeout without the feature
    ex_dREN = 1; ex_aluOut = 32'h500; dmem_if.dmemload = 32'h600DCAFE;
    @(negedge CLK); clear_ex();
    for (int k = 0; k < 6; k++) begin
      chk("lit_long_stall", {31'd0, mem_stall}, 32'd1);
      dmem_if.dhit = (k == 5);
      @(negedge CLK);
    end
    dmem_if.dhit = 0;
    chk("lit_long_data", mem_loadData, 32'h600DCAFE);
    chk("lit_long_err", {31'd0, mem_err}, 32'd0);
`endif

    repeat (3) @(negedge CLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
